// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 write-issue path: FSM encodings and burst constants.
package ddr3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } wr_state_e;

    localparam int unsigned BL8_BEATS = 4;

    // Wide enough for any byte-strobe width in use; users cast down to MASKS.
    localparam logic [63:0] DFI_MASK_IDLE = '1;

endpackage

// File: rtl/ddr3_wr_issue.sv
// BL8 write-issue stage: requests the scheduler per command, then streams four
// data beats onto DFI after the write latency, tracking packet/chunk alignment.
module ddr3_wr_issue
    import ddr3_pkg::*;
#(
    parameter int unsigned ADDRS        = 32,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MASKS        = WIDTH / 8,
    parameter int unsigned AXI_ID_WIDTH = 4,
    parameter int unsigned WR_LATENCY   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_store_i,
    output logic                    mem_accept_o,
    input  logic                    mem_wseq_i,
    input  logic [AXI_ID_WIDTH-1:0] mem_wrid_i,
    input  logic [ADDRS-1:0]        mem_addr_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic                    mem_last_i,
    input  logic [MASKS-1:0]        mem_strb_i,
    input  logic [WIDTH-1:0]        mem_data_i,
    output logic                    ctl_req_o,
    input  logic                    ctl_gnt_i,
    output logic                    ctl_seq_o,
    output logic [AXI_ID_WIDTH-1:0] ctl_wrid_o,
    output logic [ADDRS-1:0]        ctl_addr_o,
    output logic                    dfi_wren_o,
    output logic [MASKS-1:0]        dfi_mask_o,
    output logic [WIDTH-1:0]        dfi_data_o,
    output logic                    err_o
);

    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WR_LATENCY > 2 ? WR_LATENCY - 3 : 0);
    localparam logic [1:0]       LAST_BEAT = 2'(BL8_BEATS - 1);
    localparam logic [MASKS-1:0] MASK_IDLE = MASKS'(DFI_MASK_IDLE);

    wr_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              beat_q, beat_d;
    logic                    req_q, req_d;
    logic                    ready_q, ready_d;
    logic                    seq_q, seq_d;
    logic [AXI_ID_WIDTH-1:0] wrid_q, wrid_d;
    logic [ADDRS-1:0]        addr_q, addr_d;
    logic                    wren_q, wren_d;
    logic [MASKS-1:0]        mask_q, mask_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    err_q, err_d;
    logic                    in_pkt_q, in_pkt_d;

    assign mem_accept_o = req_q & ctl_gnt_i;
    assign mem_ready_o  = ready_q;
    assign ctl_req_o    = req_q;
    assign ctl_seq_o    = seq_q;
    assign ctl_wrid_o   = wrid_q;
    assign ctl_addr_o   = addr_q;
    assign dfi_wren_o   = wren_q;
    assign dfi_mask_o   = mask_q;
    assign dfi_data_o   = data_q;
    assign err_o        = err_q;

    // Next-state, latency/beat counting, DFI staging and alignment checks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        req_d    = req_q;
        ready_d  = ready_q;
        seq_d    = seq_q;
        wrid_d   = wrid_q;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        mask_d   = MASK_IDLE;
        data_d   = data_q;
        err_d    = err_q;
        in_pkt_d = in_pkt_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_store_i && mem_valid_i) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    seq_d   = mem_wseq_i;
                    wrid_d  = mem_wrid_i;
                    addr_d  = mem_addr_i;
                end
            end
            ST_REQ: begin
                if (ctl_gnt_i) begin
                    req_d = 1'b0;
                    // A continuation must follow an open packet and a fresh chunk must not.
                    if (seq_q != in_pkt_q) begin
                        err_d = 1'b1;
                    end
                    if (WR_LATENCY <= 2) begin
                        state_d = ST_SEND;
                        ready_d = 1'b1;
                        beat_d  = 2'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_SEND;
                    ready_d = 1'b1;
                    beat_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SEND: begin
                wren_d = 1'b1;
                if (mem_valid_i) begin
                    data_d = mem_data_i;
                    mask_d = ~mem_strb_i;
                end else begin
                    data_d = '0;
                    err_d  = 1'b1;
                end
                if (beat_q == LAST_BEAT) begin
                    in_pkt_d = ~mem_last_i;
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                end else begin
                    if (mem_last_i) begin
                        err_d = 1'b1;
                    end
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            req_q    <= 1'b0;
            ready_q  <= 1'b0;
            seq_q    <= 1'b0;
            wrid_q   <= '0;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            mask_q   <= MASK_IDLE;
            data_q   <= '0;
            err_q    <= 1'b0;
            in_pkt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            req_q    <= req_d;
            ready_q  <= ready_d;
            seq_q    <= seq_d;
            wrid_q   <= wrid_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            err_q    <= err_d;
            in_pkt_q <= in_pkt_d;
        end
    end

endmodule
